clic_int_arb: RTL and testbench
===============================

CLIC_INT_ARB -- requirements
Module: clic_int_arb

Interface
REQ-001 SHALL have parameter INTNUM, 64, number of external interrupt sources (multiple of GRP).
REQ-002 SHALL have parameter PRIO_BITS, 3, priority field width per source.
REQ-003 SHALL have parameter GRP, 8, sources compared per scan cycle.
REQ-004 SHALL have port forever_cpuclk  in  1  single clock; all state on its rising edge.
REQ-005 SHALL have port cpurst_b  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port pad_clic_int_vld  in  INTNUM  raw interrupt lines, pre-synchronised.
REQ-007 SHALL have port clic_int_en  in  INTNUM  per-source enable.
REQ-008 SHALL have port clic_int_prio  in  INTNUM*PRIO_BITS  per-source priority; source i at bits [i*PRIO_BITS +: PRIO_BITS].
REQ-009 SHALL have port cpu_int_thresh  in  PRIO_BITS  core threshold; only priority > thresh is eligible.
REQ-010 SHALL have port cpu_int_ack  in  1  core accepts presented interrupt.
REQ-011 SHALL have port clic_cpu_int_vld  out  1  interrupt presented.
REQ-012 SHALL have port clic_cpu_int_id  out  log2(INTNUM)  winning source ID.
REQ-013 SHALL have port clic_cpu_int_prio  out  PRIO_BITS  winning priority.
REQ-014 SHALL have port clic_arb_busy  out  1  high in SCAN or PRESENT.

Function
REQ-015 SHALL define pending[i] as the level of pad_clic_int_vld[i] (or the latch of REQ-030), and eligible[i] as pending[i] & en[i] & prio[i] > thresh.
REQ-016 SHALL implement FSM IDLE, SCAN, PRESENT.
REQ-017 IDLE: if any eligible bit is set, SHALL go to SCAN, clear scan counter and best-valid.
REQ-018 SCAN: each cycle SHALL evaluate group cnt (sources cnt*GRP .. cnt*GRP+GRP-1) live, replacing the best if best is invalid or the candidate's priority is strictly greater.
REQ-019 Ties SHALL resolve to the lower ID, both within a group and across groups.
REQ-020 After group NGRP-1 (NGRP = INTNUM/GRP), SHALL go to PRESENT if best is valid, else to IDLE.
REQ-021 Latency SHALL be: eligible in IDLE at cycle t leads to clic_cpu_int_vld high at cycle t+NGRP+1 (t+9 at defaults).
REQ-022 PRESENT: vld, id and prio SHALL be held stable until ack; thresh and priority changes SHALL NOT be re-evaluated.
REQ-023 Ack in PRESENT SHALL drop vld next cycle and return to IDLE; ack in IDLE or SCAN SHALL be ignored.
REQ-024 Level mode: if the presented source's pending deasserts before ack, SHALL withdraw vld next cycle and return to IDLE.
REQ-025 A request arriving during SCAN for a group already scanned SHALL wait for the next scan pass.

Reset
REQ-026 While cpurst_b is low at a clock edge, SHALL force state IDLE, counter 0, best invalid, pending latches 0, edge history 0.
REQ-027 Outputs at reset SHALL be vld 0, id 0, prio 0, busy 0.
REQ-028 Reset asserted mid-SCAN or mid-PRESENT SHALL abort with no ack required; a line high at release counts as a rising edge in edge mode.

Configuration
REQ-029 Macro CLIC_INT_EDGE_TRIG_EN SHALL select the trigger mode.
REQ-030 Defined: a per-source rising-edge detector SHALL set pending[i]; ack SHALL clear pending[id]; a new edge coincident with the ack SHALL win (pending stays 1); REQ-024 does not apply; latency is +1 cycle.
REQ-031 Undefined: level-sensitive, no pending latches or edge history.

Structure
REQ-032 Package clic_int_arb_pkg SHALL hold the FSM state encoding, default parameter constants, and the NGRP and ID-width derivations.
REQ-033 A single combinational sub-module clic_int_arb_grpmax (GRP-way max-priority, lowest-ID-tiebreak finder) SHALL be instantiated once.

Verification
REQ-034 Source 5 at prio 3, thresh 0 -> vld at t+9, id 5, prio 3; ack -> vld 0 next cycle, busy 0.
REQ-035 Sources 10 and 50 both at prio 4, plus source 60 at prio 2 -> id 10.
REQ-036 Source 20 at prio 2 with thresh 2 -> no vld; thresh lowered to 1 -> vld, id 20.
REQ-037 Level mode: source 7 presented, line dropped before ack -> vld withdrawn next cycle, FSM IDLE.
REQ-038 Edge mode: source 3 pulse of 1 cycle -> vld at t+10; second edge on the ack cycle -> re-presented after the next scan.
REQ-039 cpurst_b low during PRESENT -> all outputs 0 next cycle; a line still high at release re-arbitrates.

Source files
------------

// File: rtl/clic_int_arb_pkg.sv
// rtl/clic_int_arb_pkg.sv - state encoding, default constants and size derivations for the CLIC arbiter
package clic_int_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SCAN    = 2'd1,
    ST_PRESENT = 2'd2
  } arb_state_e;

  localparam int DEF_INTNUM    = 64;
  localparam int DEF_PRIO_BITS = 3;
  localparam int DEF_GRP       = 8;

  // Number of scan cycles needed to visit every source once.
  function automatic int ngrp(input int intnum, input int grp);
    return intnum / grp;
  endfunction

  // Index width for n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clic_int_arb_grpmax.sv
// rtl/clic_int_arb_grpmax.sv - GRP-way max-priority finder, lowest index wins ties
module clic_int_arb_grpmax
  import clic_int_arb_pkg::*;
#(
  parameter  int GRP       = DEF_GRP,
  parameter  int PRIO_BITS = DEF_PRIO_BITS,
  localparam int IDX_W     = idx_w(GRP)
) (
  input  logic [GRP-1:0]           i_elig,
  input  logic [GRP*PRIO_BITS-1:0] i_prio,
  output logic                     o_vld,
  output logic [IDX_W-1:0]         o_idx,
  output logic [PRIO_BITS-1:0]     o_prio
);

  logic                 w_vld;
  logic [IDX_W-1:0]     w_idx;
  logic [PRIO_BITS-1:0] w_prio;

  // Walk upward and replace only on strictly greater priority so the lowest index keeps a tie.
  always_comb begin
    w_vld  = 1'b0;
    w_idx  = '0;
    w_prio = '0;
    for (int i = 0; i < GRP; i++) begin
      if (i_elig[i] && (!w_vld || (i_prio[i*PRIO_BITS +: PRIO_BITS] > w_prio))) begin
        w_vld  = 1'b1;
        w_idx  = IDX_W'(i);
        w_prio = i_prio[i*PRIO_BITS +: PRIO_BITS];
      end
    end
  end

  assign o_vld  = w_vld;
  assign o_idx  = w_idx;
  assign o_prio = w_prio;

endmodule

// File: rtl/clic_int_arb.sv
// rtl/clic_int_arb.sv - group-serial interrupt arbiter; CLIC_INT_EDGE_TRIG_EN selects edge-triggered pending latches
module clic_int_arb
  import clic_int_arb_pkg::*;
#(
  parameter  int INTNUM    = DEF_INTNUM,
  parameter  int PRIO_BITS = DEF_PRIO_BITS,
  parameter  int GRP       = DEF_GRP,
  localparam int ID_W      = idx_w(INTNUM)
) (
  input  logic                        forever_cpuclk,
  input  logic                        cpurst_b,
  input  logic [INTNUM-1:0]           pad_clic_int_vld,
  input  logic [INTNUM-1:0]           clic_int_en,
  input  logic [INTNUM*PRIO_BITS-1:0] clic_int_prio,
  input  logic [PRIO_BITS-1:0]        cpu_int_thresh,
  input  logic                        cpu_int_ack,
  output logic                        clic_cpu_int_vld,
  output logic [ID_W-1:0]             clic_cpu_int_id,
  output logic [PRIO_BITS-1:0]        clic_cpu_int_prio,
  output logic                        clic_arb_busy
);

  localparam int               NGRP     = ngrp(INTNUM, GRP);
  localparam int               GIDX_W   = idx_w(GRP);
  localparam int               CNT_W    = idx_w(NGRP);
  localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(NGRP - 1);

  arb_state_e              r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
  logic                    r_best_vld, w_best_vld_nxt;
  logic [ID_W-1:0]         r_best_id, w_best_id_nxt;
  logic [PRIO_BITS-1:0]    r_best_prio, w_best_prio_nxt;

  logic [INTNUM-1:0]        w_pend;
  logic [INTNUM-1:0]        w_elig;
  logic [GRP-1:0]           w_grp_elig;
  logic [GRP*PRIO_BITS-1:0] w_grp_prio;
  logic                     w_grp_vld;
  logic [GIDX_W-1:0]        w_grp_idx;
  logic [PRIO_BITS-1:0]     w_grp_max;
  logic [ID_W-1:0]          w_cand_id;

`ifdef CLIC_INT_EDGE_TRIG_EN
  logic [INTNUM-1:0] r_pend;
  logic [INTNUM-1:0] r_hist;
  logic [INTNUM-1:0] w_rise;
  logic [INTNUM-1:0] w_ack_clr;

  assign w_rise    = pad_clic_int_vld & ~r_hist;
  assign w_ack_clr = ((r_state == ST_PRESENT) && cpu_int_ack) ? (INTNUM'(1) << r_best_id) : '0;

  // Latch rising edges; a fresh edge in the ack cycle re-sets the bit the ack clears.
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      r_pend <= '0;
      r_hist <= '0;
    end else begin
      r_hist <= pad_clic_int_vld;
      r_pend <= (r_pend & ~w_ack_clr) | w_rise;
    end
  end

  assign w_pend = r_pend;
`else
  assign w_pend = pad_clic_int_vld;
`endif

  for (genvar gi = 0; gi < INTNUM; gi++) begin : g_elig
    assign w_elig[gi] = w_pend[gi] & clic_int_en[gi] &
                        (clic_int_prio[gi*PRIO_BITS +: PRIO_BITS] > cpu_int_thresh);
  end

  // The current group is sampled live, so late requests in an already-scanned group wait a pass.
  assign w_grp_elig = w_elig[r_cnt*GRP +: GRP];
  assign w_grp_prio = clic_int_prio[r_cnt*GRP*PRIO_BITS +: GRP*PRIO_BITS];

  clic_int_arb_grpmax #(
    .GRP       (GRP),
    .PRIO_BITS (PRIO_BITS)
  ) u_grpmax (
    .i_elig (w_grp_elig),
    .i_prio (w_grp_prio),
    .o_vld  (w_grp_vld),
    .o_idx  (w_grp_idx),
    .o_prio (w_grp_max)
  );

  assign w_cand_id = ID_W'(int'(r_cnt) * GRP + int'(w_grp_idx));

  // Next-state and best-candidate tracking; strict compare keeps the earlier (lower-ID) group on ties.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_best_vld_nxt  = r_best_vld;
    w_best_id_nxt   = r_best_id;
    w_best_prio_nxt = r_best_prio;
    unique case (r_state)
      ST_IDLE: begin
        if (|w_elig) begin
          w_state_nxt    = ST_SCAN;
          w_cnt_nxt      = '0;
          w_best_vld_nxt = 1'b0;
        end
      end
      ST_SCAN: begin
        if (w_grp_vld && (!r_best_vld || (w_grp_max > r_best_prio))) begin
          w_best_vld_nxt  = 1'b1;
          w_best_id_nxt   = w_cand_id;
          w_best_prio_nxt = w_grp_max;
        end
        if (r_cnt == LAST_GRP) begin
          w_state_nxt = w_best_vld_nxt ? ST_PRESENT : ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_PRESENT: begin
        if (cpu_int_ack) begin
          w_state_nxt    = ST_IDLE;
          w_best_vld_nxt = 1'b0;
        end
`ifndef CLIC_INT_EDGE_TRIG_EN
        else if (!w_pend[r_best_id]) begin
          w_state_nxt    = ST_IDLE;
          w_best_vld_nxt = 1'b0;
        end
`endif
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and best-candidate registers.
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_best_vld  <= 1'b0;
      r_best_id   <= '0;
      r_best_prio <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_best_vld  <= w_best_vld_nxt;
      r_best_id   <= w_best_id_nxt;
      r_best_prio <= w_best_prio_nxt;
    end
  end

  assign clic_cpu_int_vld  = (r_state == ST_PRESENT);
  assign clic_cpu_int_id   = clic_cpu_int_vld ? r_best_id : '0;
  assign clic_cpu_int_prio = clic_cpu_int_vld ? r_best_prio : '0;
  assign clic_arb_busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_clic_int_arb.sv
// tb/tb_clic_int_arb.sv - scoreboard bench for clic_int_arb
module tb_clic_int_arb;

  localparam int N  = 64;
  localparam int PB = 3;
`ifdef CLIC_INT_EDGE_TRIG_EN
  localparam int LAT = 10;
`else
  localparam int LAT = 9;
`endif

  logic            clk = 1'b0;
  logic            rstb;
  logic [N-1:0]    pad;
  logic [N-1:0]    en;
  logic [N*PB-1:0] prio;
  logic [PB-1:0]   thresh;
  logic            ack;
  logic            vld;
  logic [5:0]      id;
  logic [PB-1:0]   oprio;
  logic            busy;

  always #5 clk = ~clk;

  clic_int_arb dut (
    .forever_cpuclk    (clk),
    .cpurst_b          (rstb),
    .pad_clic_int_vld  (pad),
    .clic_int_en       (en),
    .clic_int_prio     (prio),
    .cpu_int_thresh    (thresh),
    .cpu_int_ack       (ack),
    .clic_cpu_int_vld  (vld),
    .clic_cpu_int_id   (id),
    .clic_cpu_int_prio (oprio),
    .clic_arb_busy     (busy)
  );

  typedef struct {
    int id;
    int prio;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic v, input int p);
    pad[i] = v;
    prio[i*PB +: PB] = PB'(p);
  endtask

  task automatic push_exp(input int i, input int p);
    exp_t e;
    e.id   = i;
    e.prio = p;
    sb_q.push_back(e);
  endtask

  task automatic wait_present(input string tag, input int budget, output int lat);
    exp_t e;
    lat = 0;
    while (!vld && lat < budget) begin
      tick;
      lat++;
    end
    chk({tag, "_vld"}, int'(vld), 1);
    if (sb_q.size() == 0) begin
      n_chk++;
      $display("FAIL %s_sb: got empty queue expected an entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_id"}, int'(id), e.id);
      chk({tag, "_prio"}, int'(oprio), e.prio);
    end
  endtask

  task automatic do_ack(input string tag, input int drop_id);
    ack = 1'b1;
    pad[drop_id] = 1'b0;
    tick;
    ack = 1'b0;
    chk({tag, "_ackvld"}, int'(vld), 0);
  endtask

  task automatic clean;
    pad    = '0;
    en     = '1;
    prio   = '0;
    thresh = '0;
    ack    = 1'b0;
    rstb   = 1'b0;
    tick;
    tick;
    rstb   = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int  lat;
    int  seen;

    // reset state
    pad = '0; en = '1; prio = '0; thresh = '0; ack = 1'b0; rstb = 1'b0;
    set_src(9, 1'b1, 5);
    tick;
    tick;
    chk("rst_vld", int'(vld), 0);
    chk("rst_id", int'(id), 0);
    chk("rst_prio", int'(oprio), 0);
    chk("rst_busy", int'(busy), 0);

    // single source, exact latency, ack
    clean;
    set_src(5, 1'b1, 3);
    push_exp(5, 3);
    wait_present("s5", 20, lat);
    chk("s5_lat", lat, LAT);
    do_ack("s5", 5);
    chk("s5_busy", int'(busy), 0);

    // cross-group tie resolves to lower id
    clean;
    set_src(10, 1'b1, 4);
    set_src(50, 1'b1, 4);
    set_src(60, 1'b1, 2);
    push_exp(10, 4);
    wait_present("tie_x", 20, lat);
    do_ack("tie_x", 10);

    // threshold blocks equal priority, then admits it
    clean;
    thresh = 3'd2;
    set_src(20, 1'b1, 2);
    seen = 0;
    for (int k = 0; k < 14; k++) begin
      tick;
      if (vld) seen = 1;
    end
    chk("thr_block", seen, 0);
    thresh = 3'd1;
    push_exp(20, 2);
    wait_present("thr", 20, lat);
    do_ack("thr", 20);

    // in-group tie plus stability while presented
    clean;
    set_src(16, 1'b1, 1);
    set_src(17, 1'b1, 6);
    set_src(18, 1'b1, 6);
    push_exp(17, 6);
    wait_present("tie_g", 20, lat);
    thresh = 3'd7;
    prio[17*PB +: PB] = 3'd0;
    tick;
    tick;
    tick;
    chk("hold_vld", int'(vld), 1);
    chk("hold_id", int'(id), 17);
    chk("hold_prio", int'(oprio), 6);
    do_ack("tie_g", 17);

    // ack during scan is ignored
    clean;
    set_src(40, 1'b1, 5);
    tick;
    tick;
    tick;
    ack = 1'b1;
    tick;
    ack = 1'b0;
    push_exp(40, 5);
    wait_present("scan_ack", 20, lat);
    chk("scan_ack_lat", lat + 4, LAT);
    do_ack("scan_ack", 40);

    // disabled source is skipped
    clean;
    set_src(30, 1'b1, 7);
    set_src(31, 1'b1, 1);
    en[30] = 1'b0;
    push_exp(31, 1);
    wait_present("en", 20, lat);
    do_ack("en", 31);

    // late request in an already-scanned group waits for the next pass
    clean;
    set_src(60, 1'b1, 1);
    push_exp(60, 1);
    push_exp(2, 7);
    tick;
    tick;
    tick;
    set_src(2, 1'b1, 7);
    wait_present("late0", 20, lat);
    do_ack("late0", 60);
    wait_present("late1", 20, lat);
    do_ack("late1", 2);

`ifndef CLIC_INT_EDGE_TRIG_EN
    // level withdraw before ack
    clean;
    set_src(7, 1'b1, 5);
    push_exp(7, 5);
    wait_present("lvl", 20, lat);
    pad[7] = 1'b0;
    tick;
    chk("lvl_wd_vld", int'(vld), 0);
    chk("lvl_wd_busy", int'(busy), 0);
`else
    // edge pulse latency and an edge coincident with ack
    clean;
    set_src(3, 1'b1, 3);
    tick;
    pad[3] = 1'b0;
    push_exp(3, 3);
    wait_present("edg", 20, lat);
    chk("edg_lat", lat + 1, 10);
    pad[3] = 1'b1;
    ack = 1'b1;
    tick;
    ack = 1'b0;
    pad[3] = 1'b0;
    chk("edg_ackvld", int'(vld), 0);
    push_exp(3, 3);
    wait_present("edg2", 20, lat);
    chk("edg2_lat", lat, 9);
    do_ack("edg2", 3);
`endif

    // reset while presenting, line still high re-arbitrates
    clean;
    set_src(12, 1'b1, 4);
    push_exp(12, 4);
    wait_present("rp", 20, lat);
    rstb = 1'b0;
    tick;
    chk("rp_vld", int'(vld), 0);
    chk("rp_id", int'(id), 0);
    chk("rp_prio", int'(oprio), 0);
    chk("rp_busy", int'(busy), 0);
    rstb = 1'b1;
    push_exp(12, 4);
    wait_present("rp2", 20, lat);
    chk("rp2_lat", lat, LAT);
    do_ack("rp2", 12);

    chk("sb_drain", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
